// File: rtl/dpwm_multiphase.sv
// Four-phase interleaved DPWM with complementary high/low-side drives and dead-time gating.
// Build option: define DPWM_DEADTIME_EN to include per-phase dead-time run counters.
module dpwm_multiphase #(
  parameter int DT = 2
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       en,
  input  logic [6:0] d_dith,
  output logic [3:0] pwm_hs,
  output logic [3:0] pwm_ls,
  output logic       period_start
);

  if (DT < 0 || DT > 15) begin : g_dt_range
    $error("dpwm_multiphase: DT must be in 0..15");
  end

  logic [6:0] cnt_q, cnt_d;
  logic       ps_cmp_q, ps_cmp_d;
  logic       ps_q, ps_d;
  logic [3:0] hs_q, hs_d;
  logic [3:0] ls_q, ls_d;

  // Start marker travels through the same two register stages as the drives.
  always_comb begin
    cnt_d    = en ? cnt_q + 7'd1 : 7'd0;
    ps_cmp_d = en && (cnt_q == 7'd0);
    ps_d     = en && ps_cmp_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_q    <= 7'd0;
      ps_cmp_q <= 1'b0;
      ps_q     <= 1'b0;
      hs_q     <= 4'd0;
      ls_q     <= 4'd0;
    end else begin
      cnt_q    <= cnt_d;
      ps_cmp_q <= ps_cmp_d;
      ps_q     <= ps_d;
      hs_q     <= hs_d;
      ls_q     <= ls_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_phase
      localparam logic [6:0] OFFS = 7'(32 * gi);

      logic [6:0] loc;
      logic [6:0] duty_sh_q, duty_sh_d;
      logic       raw;
      logic       raw_q, raw_d;
      logic       gate;

      assign loc = cnt_q - OFFS;
      assign raw = loc < duty_sh_q;

      // Shadow duty reloads on the last count of this phase's own period.
      always_comb begin
        duty_sh_d = duty_sh_q;
        if (!en || loc == 7'd127) begin
          duty_sh_d = d_dith;
        end
        raw_d = en && raw;
      end

      always_ff @(posedge clk_in) begin
        if (rst) begin
          duty_sh_q <= 7'd0;
          raw_q     <= 1'b0;
        end else begin
          duty_sh_q <= duty_sh_d;
          raw_q     <= raw_d;
        end
      end

`ifdef DPWM_DEADTIME_EN
      localparam logic [3:0] DT_C = 4'(DT);
      logic [3:0] rc_q, rc_d;

      // rc counts cycles since the last raw edge; drives open only once it reaches DT.
      always_comb begin
        if (!en || (raw != raw_q)) begin
          rc_d = 4'd0;
        end else if (rc_q < DT_C) begin
          rc_d = rc_q + 4'd1;
        end else begin
          rc_d = rc_q;
        end
      end

      always_ff @(posedge clk_in) begin
        if (rst) begin
          rc_q <= 4'd0;
        end else begin
          rc_q <= rc_d;
        end
      end

      assign gate = (rc_q >= DT_C);
`else
      assign gate = 1'b1;
`endif

      assign hs_d[gi] = en && raw_q && gate;
      assign ls_d[gi] = en && !raw_q && gate;
    end
  endgenerate

  assign pwm_hs       = hs_q;
  assign pwm_ls       = ls_q;
  assign period_start = ps_q;

endmodule

// File: tb/tb_dpwm_multiphase.sv
// Randomized + directed bench for dpwm_multiphase against a cycle-history reference model.
// Honors DPWM_DEADTIME_EN the same way the design does.
module tb_dpwm_multiphase;
  localparam int DT   = 2;
  localparam int NCYC = 8192;
`ifdef DPWM_DEADTIME_EN
  localparam bit DT_ON = 1'b1;
`else
  localparam bit DT_ON = 1'b0;
`endif

  logic       clk_in = 1'b0;
  logic       rst;
  logic       en;
  logic [6:0] d_dith;
  logic [3:0] pwm_hs;
  logic [3:0] pwm_ls;
  logic       period_start;

  dpwm_multiphase #(.DT(DT)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .en          (en),
    .d_dith      (d_dith),
    .pwm_hs      (pwm_hs),
    .pwm_ls      (pwm_ls),
    .period_start(period_start)
  );

  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference history: per applied cycle, whether the block ran, its count and raw compare.
  bit       valid_h[NCYC];
  bit [6:0] cnt_h[NCYC];
  bit [3:0] raw_h[NCYC];
  bit [6:0] m_cnt = 7'd0;
  bit [6:0] m_sh[4];

  int n_hs0, n_ls0, ps_mark;
  int r0, r1, r3;
  int run0, run2;
  int w0[$];
  int w2[$];
  logic [3:0] prev_hs = 4'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  // Value held in the raw register during cycle k (cleared when the previous cycle was idle).
  function automatic bit rq(int k, int i);
    if (k < 1) return 1'b0;
    return valid_h[k-1] ? raw_h[k-1][i] : 1'b0;
  endfunction

  // A drive is on when the registered raw level has been stable for DT more running cycles.
  function automatic void expect_drive(int m, int i, output bit hs, output bit ls);
    bit v;
    bit ok;
    hs = 1'b0;
    ls = 1'b0;
    if (m < 1 || !valid_h[m-1]) return;
    v  = rq(m-1, i);
    ok = 1'b1;
    if (DT_ON) begin
      for (int j = 1; j <= DT; j++) begin
        if (m - 1 - j < 0) ok = 1'b0;
        else if (!valid_h[m-1-j] || rq(m-1-j, i) != v) ok = 1'b0;
      end
    end
    hs = v && ok;
    ls = !v && ok;
  endfunction

  task automatic tick(input bit r, input bit e, input logic [6:0] d);
    logic [6:0] loc;
    bit [3:0] ehs;
    bit [3:0] els;
    bit       eps;
    bit       b_hs;
    bit       b_ls;
    if (cyc >= NCYC - 1) begin
      $display("FAIL cycle_budget cyc=%0d got=overrun expected=<%0d", cyc, NCYC);
      $fatal(1, "cycle budget exhausted");
    end
    rst    = r;
    en     = e;
    d_dith = d;
    valid_h[cyc] = e && !r;
    cnt_h[cyc]   = m_cnt;
    for (int i = 0; i < 4; i++) begin
      loc = m_cnt - 7'(32 * i);
      raw_h[cyc][i] = (loc < m_sh[i]);
      if (r) m_sh[i] = 7'd0;
      else if (!e || loc == 7'd127) m_sh[i] = d;
    end
    m_cnt = r ? 7'd0 : (e ? m_cnt + 7'd1 : 7'd0);

    @(posedge clk_in);
    #1;
    cyc++;

    for (int i = 0; i < 4; i++) begin
      expect_drive(cyc, i, b_hs, b_ls);
      ehs[i] = b_hs;
      els[i] = b_ls;
    end
    eps = (cyc >= 2) && valid_h[cyc-1] && valid_h[cyc-2] && (cnt_h[cyc-2] == 7'd0);
    check("hs", pwm_hs, ehs);
    check("ls", pwm_ls, els);
    check("period_start", period_start, eps);
    check("overlap", pwm_hs & pwm_ls, 0);

    if (pwm_hs[0] === 1'b1) n_hs0++;
    if (pwm_ls[0] === 1'b1) n_ls0++;
    if (period_start === 1'b1 && ps_mark < 0) ps_mark = cyc;
    if (pwm_hs[0] === 1'b1 && prev_hs[0] !== 1'b1 && r0 < 0) r0 = cyc;
    if (pwm_hs[1] === 1'b1 && prev_hs[1] !== 1'b1 && r0 >= 0 && r1 < 0) r1 = cyc;
    if (pwm_hs[3] === 1'b1 && prev_hs[3] !== 1'b1 && r0 >= 0 && r3 < 0) r3 = cyc;
    if (pwm_hs[0] === 1'b1) run0++;
    else if (run0 > 0) begin w0.push_back(run0); run0 = 0; end
    if (pwm_hs[2] === 1'b1) run2++;
    else if (run2 > 0) begin w2.push_back(run2); run2 = 0; end
    prev_hs = pwm_hs;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t_ref;
    int off_left;
    int rst_left;
    logic [6:0] d;
    rst = 1'b1; en = 1'b0; d_dith = 7'd0;
    ps_mark = -1; r0 = -1; r1 = -1; r3 = -1; run0 = 0; run2 = 0;
    #1;

    // Reset with enable held high; first start marker two stages after cnt=0.
    repeat (3) tick(1'b1, 1'b1, 7'd64);
    check("reset_hs", pwm_hs, 0);
    check("reset_ls", pwm_ls, 0);
    t_ref = cyc;
    ps_mark = -1;
    repeat (8) tick(1'b0, 1'b1, 7'd64);
    check("first_ps_latency", ps_mark - t_ref, 2);

    // Steady duty 32: widths per period and interleave offsets.
    repeat (300) tick(1'b0, 1'b1, 7'd32);
    n_hs0 = 0; n_ls0 = 0;
    repeat (128) tick(1'b0, 1'b1, 7'd32);
    check("steady_hs0_count", n_hs0, DT_ON ? 30 : 32);
    check("steady_ls0_count", n_ls0, DT_ON ? 94 : 96);
    r0 = -1; r1 = -1; r3 = -1;
    repeat (256) tick(1'b0, 1'b1, 7'd32);
    check("hs1_lag", r1 - r0, 32);
    check("hs3_lag", r3 - r0, 96);

    // Duty change 32->64 at cnt=10: each phase adopts it at its own boundary.
    while (m_cnt != 7'd10) tick(1'b0, 1'b1, 7'd32);
    w0.delete(); w2.delete();
    repeat (257) tick(1'b0, 1'b1, 7'd64);
    check("mid_w0_pulses", w0.size() >= 2, 1);
    check("mid_w2_pulses", w2.size() >= 1, 1);
    if (w0.size() >= 2) begin
      check("mid_w0_current", w0[0], DT_ON ? 30 : 32);
      check("mid_w0_next", w0[1], DT_ON ? 62 : 64);
    end
    if (w2.size() >= 1) check("mid_w2_current", w2[0], DT_ON ? 62 : 64);

    // Boundary duties.
    repeat (300) tick(1'b0, 1'b1, 7'd0);
    n_hs0 = 0; n_ls0 = 0;
    repeat (128) tick(1'b0, 1'b1, 7'd0);
    check("d0_hs0_count", n_hs0, 0);
    check("d0_ls0_count", n_ls0, 128);
    repeat (300) tick(1'b0, 1'b1, 7'd1);
    n_hs0 = 0; n_ls0 = 0;
    repeat (128) tick(1'b0, 1'b1, 7'd1);
    check("d1_hs0_count", n_hs0, DT_ON ? 0 : 1);
    check("d1_ls0_count", n_ls0, DT_ON ? 125 : 127);

    // Enable drop at cnt=50 and restart.
    repeat (200) tick(1'b0, 1'b1, 7'd100);
    while (m_cnt != 7'd50) tick(1'b0, 1'b1, 7'd100);
    tick(1'b0, 1'b0, 7'd100);
    check("en_drop_hs", pwm_hs, 0);
    check("en_drop_ls", pwm_ls, 0);
    repeat (5) tick(1'b0, 1'b0, 7'd100);
    t_ref = cyc;
    ps_mark = -1;
    repeat (10) tick(1'b0, 1'b1, 7'd100);
    check("en_restart_ps_latency", ps_mark - t_ref, 2);

    // Randomized duty, enable and reset activity.
    off_left = 0; rst_left = 0;
    d = 7'($urandom_range(0, 127));
    repeat (3000) begin
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 4))
          0: d = 7'd0;
          1: d = 7'd1;
          2: d = 7'd127;
          default: d = 7'($urandom_range(0, 127));
        endcase
      end
      if (off_left == 0 && $urandom_range(0, 149) == 0) off_left = $urandom_range(1, 10);
      if (rst_left == 0 && $urandom_range(0, 999) == 0) rst_left = $urandom_range(1, 2);
      tick(rst_left > 0, off_left == 0, d);
      if (off_left > 0) off_left--;
      if (rst_left > 0) rst_left--;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dpwm_multiphase.md
DPWM_MULTIPHASE -- requirements
Module: dpwm_multiphase

Interface
REQ-001 Parameter: DT, default 2, dead-time length in clk_in cycles, legal range 0..15.
REQ-002 Port: clk_in, input, 1, the single clock.
REQ-003 Port: rst, input, 1, synchronous active-high reset.
REQ-004 Port: en, input, 1, converter enable; low forces the safe state.
REQ-005 Port: d_dith, input, 7, dithered duty command in counts of 1/128 period, from the dither stage.
REQ-006 Port: pwm_hs, output, 4, high-side gate drive, bit i = phase i.
REQ-007 Port: pwm_ls, output, 4, low-side gate drive, bit i = phase i.
REQ-008 Port: period_start, output, 1, one-cycle pulse marking phase-0 period start.

Function
REQ-009 The block SHALL hold a 7-bit period counter cnt that counts 0..127 and wraps 127->0 while en=1.
REQ-010 The block SHALL compute the phase-i local count as loc_i = (cnt - 32*i) mod 128, for i = 0..3 (90-degree interleave).
REQ-011 The block SHALL keep a 7-bit shadow duty duty_sh_i per phase, loaded from d_dith on the cycle where loc_i == 127, so a new duty takes effect at that phase's next loc_i == 0.
REQ-012 A d_dith change mid-period SHALL NOT alter a phase's current period; each phase picks it up at its own boundary.
REQ-013 The raw PWM for phase i SHALL be raw_i = (loc_i < duty_sh_i), registered into raw_q_i, which adds one cycle of latency.
REQ-014 Duty 0 SHALL give raw_i constantly 0; duty 127 SHALL give raw_i high for 127 of 128 cycles. No 100% duty exists.
REQ-015 Each phase SHALL have a 4-bit run counter rc_i that clears when raw_i differs from raw_q_i, otherwise increments, saturating at DT.
REQ-016 pwm_hs[i] SHALL be registered as raw_q_i AND (rc_i >= DT).
REQ-017 pwm_ls[i] SHALL be registered as NOT raw_q_i AND (rc_i >= DT).
REQ-018 Resulting pulse widths: a raw high interval of W cycles SHALL yield an hs pulse of max(W-DT,0) cycles; a raw low interval of L cycles SHALL yield an ls pulse of max(L-DT,0) cycles.
REQ-019 pwm_hs[i] and pwm_ls[i] SHALL never both be 1 in any cycle.
REQ-020 period_start SHALL pulse high for exactly one cycle, aligned with the output register stage, once per 128 cycles, for the compare where cnt == 0.
REQ-021 While en=0: cnt SHALL hold 0, all rc_i and raw_q_i SHALL clear, all outputs SHALL be 0, and duty_sh_i SHALL load d_dith every cycle.
REQ-022 When en goes 0->1, counting SHALL resume from cnt=0 with fresh shadow duties.
REQ-023 en dropping mid-period SHALL force all outputs to 0 on the next clk_in edge.

Reset
REQ-024 On rst=1 at a clk_in edge: cnt=0, duty_sh_i=0, raw_q_i=0, rc_i=0, pwm_hs=0, pwm_ls=0, period_start=0.
REQ-025 rst SHALL take priority over en.
REQ-026 After reset release with en=1, the first period_start SHALL occur at the compare stage of cnt=0.

Configuration
REQ-027 Macro DPWM_DEADTIME_EN, when defined, SHALL compile in the rc_i counters and the DT gating of REQ-015 to REQ-018.
REQ-028 When DPWM_DEADTIME_EN is undefined, the rc_i counters SHALL be absent, DT SHALL be ignored, pwm_hs[i] SHALL equal raw_q_i, and pwm_ls[i] SHALL equal NOT raw_q_i (while en=1).

Verification
REQ-029 Reset scenario: assert rst for 3 cycles with en=1 and d_dith=64 -> all outputs 0, and the first period_start occurs on the cycle after the cnt=0 compare.
REQ-030 Steady duty scenario: d_dith=32, DT=2 -> per 128 cycles pwm_hs[0] high for 30 cycles and pwm_ls[0] high for 94 cycles; pwm_hs[1] rises 32 cycles after pwm_hs[0], and pwm_hs[3] rises 96 cycles after pwm_hs[0].
REQ-031 Mid-period change scenario: d_dith goes 32->64 at cnt=10 -> phase 0 keeps a 30-cycle hs pulse this period and gives 62 next period; phase 2 gives 62 in the current period.
REQ-032 Boundary scenario: d_dith=0 -> pwm_hs never high and pwm_ls stays high continuously after DT; d_dith=1 with DT=2 -> no hs pulse and a 125-cycle ls pulse.
REQ-033 Enable scenario: drop en at cnt=50 with d_dith=100 -> outputs 0 the next cycle; raise en again -> counting restarts at cnt=0 with no overlap of hs and ls.
REQ-034 Configuration scenario: build without DPWM_DEADTIME_EN, d_dith=32 -> pwm_hs[0] high for 32 cycles and pwm_ls[0] high for 96 cycles, exactly complementary.
